// File: rtl/peripheral_msi_arbiter_upsizer_wb.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_arbiter_upsizer_wb
// Function : Round-robin Wishbone arbiter with cycle-locked grant and
//            watchdog, feeding the narrow slave port of the upsizer.
// Revision : 1.0
// ============================================================================
module peripheral_msi_arbiter_upsizer_wb #(
  parameter int NUM_MASTERS = 4,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int c_IW = $clog2(NUM_MASTERS);
  localparam int c_SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TOUT = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [c_IW-1:0]        r_gidx, w_gidx_nxt;
  logic [c_IW-1:0]        r_last, w_last_nxt;
  logic [c_IW-1:0]        w_arb_idx;
  logic                   w_arb_found;
  logic [15:0]            r_wdog, w_wdog_nxt;

  logic                   w_own_cyc, w_own_stb, w_own_we;
  logic [AW-1:0]          w_own_adr;
  logic [DW-1:0]          w_own_dat;
  logic [c_SW-1:0]        w_own_sel;
  logic [2:0]             w_own_cti;
  logic [1:0]             w_own_bte;
  logic                   w_busy, w_resp;

  // Cyclic search starting just after the last owner
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!w_arb_found && wbm_cyc_i[(int'(r_last) + i) % NUM_MASTERS]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = c_IW'((int'(r_last) + i) % NUM_MASTERS);
      end
    end
  end

  // One-hot AND-OR mux; an empty grant yields all-zero outputs
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    w_own_cti = '0;
    w_own_bte = '0;
    for (int n = 0; n < NUM_MASTERS; n++) begin
      if (r_grant[n]) begin
        w_own_cyc = w_own_cyc | wbm_cyc_i[n];
        w_own_stb = w_own_stb | wbm_stb_i[n];
        w_own_we  = w_own_we  | wbm_we_i[n];
        w_own_adr = w_own_adr | wbm_adr_i[n*AW +: AW];
        w_own_dat = w_own_dat | wbm_dat_i[n*DW +: DW];
        w_own_sel = w_own_sel | wbm_sel_i[n*c_SW +: c_SW];
        w_own_cti = w_own_cti | wbm_cti_i[n*3 +: 3];
        w_own_bte = w_own_bte | wbm_bte_i[n*2 +: 2];
      end
    end
  end

  assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_busy = (r_state == S_BUSY);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_grant_nxt            = '0;
          w_grant_nxt[w_arb_idx] = 1'b1;
          w_gidx_nxt             = w_arb_idx;
          w_state_nxt            = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_own_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
        end else if (w_own_stb && !w_resp) begin
          // Expires on the TIMEOUT-th consecutive unanswered strobe cycle
          if (r_wdog == 16'(TIMEOUT - 1)) begin
            w_state_nxt = S_TOUT;
          end else begin
            w_wdog_nxt = r_wdog + 16'd1;
          end
        end
      end
      S_TOUT: begin
        if (w_own_cyc) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= c_IW'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  assign wbs_cyc_o = w_busy & w_own_cyc;
  assign wbs_stb_o = w_busy & w_own_stb;
  assign wbs_we_o  = w_own_we;
  assign wbs_adr_o = w_own_adr;
  assign wbs_dat_o = w_own_dat;
  assign wbs_sel_o = w_own_sel;
  assign wbs_cti_o = w_own_cti;
  assign wbs_bte_o = w_own_bte;

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = (w_busy && wbs_ack_i) ? r_grant : '0;
  assign wbm_rty_o = (w_busy && wbs_rty_i) ? r_grant : '0;
  assign wbm_err_o = ((w_busy && wbs_err_i) || (r_state == S_TOUT)) ? r_grant : '0;
  assign grant_o   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_arbiter_upsizer_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_msi_arbiter_upsizer_wb
// Function : Randomized masters and upsizer stub against a transaction-level
//            ownership model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_peripheral_msi_arbiter_upsizer_wb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SW   = DW / 8;
  localparam int TO   = 8;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i, wbs_err_i, wbs_rty_i;

  peripheral_msi_arbiter_upsizer_wb #(
    .NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Master behaviour
  logic          m_cyc[N], m_stb[N], m_we[N], m_burst[N];
  logic [AW-1:0] m_adr[N];
  logic [DW-1:0] m_dat[N];
  logic [SW-1:0] m_sel[N];
  logic [2:0]    m_cti[N];
  int            m_beats[N], m_idle[N];

  // Ownership model: owner=-1 means nobody holds the bus
  int owner, last, stall;
  bit tout;

  // Upsizer stub
  int sl_wait, sl_lat, sl_kind;

  // Expectations for the current cycle
  logic [N-1:0]  e_grant, e_ack, e_err, e_rty;
  logic          e_cyc, e_stb, ack_i, err_i, rty_i;
  logic [DW-1:0] rdat;
  bit            did_rst;

  task automatic new_beat(input int n);
    m_adr[n] = AW'($urandom) & ~AW'(3);
    m_dat[n] = DW'($urandom);
    m_sel[n] = SW'($urandom);
    m_we[n]  = 1'($urandom);
    m_cti[n] = (m_beats[n] == 1) ? (m_burst[n] ? 3'b111 : 3'b000) : 3'b010;
  endtask

  task automatic start_txn(input int n);
    m_beats[n] = $urandom_range(1, 4);
    m_burst[n] = (m_beats[n] > 1);
    m_cyc[n]   = 1'b1;
    m_stb[n]   = 1'b1;
    new_beat(n);
  endtask

  task automatic drop(input int n);
    m_cyc[n]  = 1'b0;
    m_stb[n]  = 1'b0;
    m_cti[n]  = 3'b000;
    m_idle[n] = $urandom_range(0, 3);
  endtask

  task automatic new_slave_beat();
    int r;
    sl_wait = 0;
    sl_lat  = ($urandom_range(0, 15) < 2) ? 1000 : int'($urandom_range(0, 3));
    r       = $urandom_range(0, 15);
    sl_kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
  endtask

  task automatic reset_model();
    owner = -1;
    last  = N - 1;
    stall = 0;
    tout  = 1'b0;
  endtask

  task automatic drive_inputs();
    logic [N-1:0] one;
    logic         hit;
    one = 1;
    for (int n = 0; n < N; n++) begin
      wbm_cyc_i[n]           = m_cyc[n];
      wbm_stb_i[n]           = m_stb[n];
      wbm_we_i[n]            = m_we[n];
      wbm_adr_i[n*AW +: AW]  = m_adr[n];
      wbm_dat_i[n*DW +: DW]  = m_dat[n];
      wbm_sel_i[n*SW +: SW]  = m_sel[n];
      wbm_cti_i[n*3 +: 3]    = m_cti[n];
      wbm_bte_i[n*2 +: 2]    = 2'b00;
    end
    e_grant = '0;
    e_cyc   = 1'b0;
    e_stb   = 1'b0;
    if (owner >= 0) begin
      e_grant = one << owner;
      e_cyc   = !tout && m_cyc[owner];
      e_stb   = !tout && m_stb[owner];
    end
    hit   = e_stb && (sl_wait >= sl_lat);
    ack_i = hit && (sl_kind == 0);
    err_i = hit && (sl_kind == 1);
    rty_i = hit && (sl_kind == 2);
    rdat  = DW'($urandom);
    wbs_ack_i = ack_i;
    wbs_err_i = err_i;
    wbs_rty_i = rty_i;
    wbs_dat_i = rdat;
    e_ack = ack_i ? e_grant : '0;
    e_rty = rty_i ? e_grant : '0;
    e_err = (tout || err_i) ? e_grant : '0;
  endtask

  task automatic check_cycle();
    check("grant", 64'(grant_o), 64'(e_grant));
    check("wbs_cyc", 64'(wbs_cyc_o), 64'(e_cyc));
    check("wbs_stb", 64'(wbs_stb_o), 64'(e_stb));
    check("ack", 64'(wbm_ack_o), 64'(e_ack));
    check("err", 64'(wbm_err_o), 64'(e_err));
    check("rty", 64'(wbm_rty_o), 64'(e_rty));
    check("rdat", 64'(wbm_dat_o), 64'(rdat));
    if (e_cyc) begin
      check("adr", 64'(wbs_adr_o), 64'(m_adr[owner]));
      check("wdat", 64'(wbs_dat_o), 64'(m_dat[owner]));
      check("ctl", 64'({wbs_we_o, wbs_sel_o, wbs_cti_o, wbs_bte_o}),
            64'({m_we[owner], m_sel[owner], m_cti[owner], 2'b00}));
    end
  endtask

  task automatic advance();
    // Arbiter rules, applied to what was driven this cycle
    if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (owner < 0 && m_cyc[(last + i) % N]) owner = (last + i) % N;
      end
      stall = 0;
    end else if (!m_cyc[owner]) begin
      last  = owner;
      owner = -1;
      tout  = 1'b0;
      stall = 0;
    end else if (tout) begin
      tout = 1'b0;
    end else if (e_stb && !(ack_i || err_i || rty_i)) begin
      stall++;
      if (stall == TO) begin
        tout  = 1'b1;
        stall = 0;
      end
    end else begin
      stall = 0;
    end

    if (e_stb && !(ack_i || err_i || rty_i)) sl_wait++;
    else new_slave_beat();

    for (int n = 0; n < N; n++) begin
      if (!m_cyc[n]) begin
        if (m_idle[n] > 0) m_idle[n]--;
        else start_txn(n);
      end else if (e_err[n] || e_rty[n]) begin
        drop(n);
      end else if (e_ack[n]) begin
        m_beats[n]--;
        if (m_beats[n] == 0) drop(n);
        else begin
          new_beat(n);
          m_stb[n] = ($urandom_range(0, 3) != 0);
        end
      end else if (!m_stb[n]) begin
        m_stb[n] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    did_rst = 1'b0;
    for (int n = 0; n < N; n++) begin
      m_beats[n] = 0;
      m_burst[n] = 1'b0;
      m_we[n]    = 1'b0;
      m_adr[n]   = '0;
      m_dat[n]   = '0;
      m_sel[n]   = '0;
      drop(n);
    end
    reset_model();
    new_slave_beat();
    drive_inputs();
    #2;
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_cyc", 64'(wbs_cyc_o), 64'(0));
    check("rst_stb", 64'(wbs_stb_o), 64'(0));
    check("rst_ack", 64'(wbm_ack_o), 64'(0));
    check("rst_err", 64'(wbm_err_o), 64'(0));
    check("rst_rty", 64'(wbm_rty_o), 64'(0));
    check("rst_adr", 64'(wbs_adr_o), 64'(0));
    check("rst_wdat", 64'(wbs_dat_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < NCYC; t++) begin
      drive_inputs();
      @(negedge clk);
      check_cycle();
      if (!did_rst && t >= 700 && owner == 0 && e_cyc) begin
        // Asynchronous reset in the middle of master 0's transfer
        did_rst = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 64'(grant_o), 64'(0));
        check("arst_cyc", 64'(wbs_cyc_o), 64'(0));
        check("arst_stb", 64'(wbs_stb_o), 64'(0));
        check("arst_ack", 64'(wbm_ack_o | wbm_err_o | wbm_rty_o), 64'(0));
        reset_model();
        new_slave_beat();
        for (int n = 1; n < N; n++) begin
          drop(n);
          m_idle[n] = 6;
        end
        start_txn(0);
        drive_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        advance();
        @(posedge clk);
        #1;
      end
    end

    check("rst_seen", 64'(did_rst), 64'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peripheral_msi_arbiter_upsizer_wb.md
Name: peripheral_msi_arbiter_upsizer_wb

Overview:
Round-robin Wishbone arbiter that shares one narrow-side slave port of the upsizer (DW_IN data) among NUM_MASTERS requesters.
- Grant is locked for a whole Wishbone cycle, so classic and incrementing/wrap bursts are never split.
- A watchdog terminates transfers that are never acknowledged.
- Sits directly in front of the upsizer's wbs_* port.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
DW, 32, data width, equal to the upsizer's DW_IN
AW, 32, address width
TIMEOUT, 255, cycles a strobed beat may wait for ack/err/rty before the watchdog fires (1..65535)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
wbm_adr_i  in  NUM_MASTERS*AW  master addresses, master n at [n*AW +: AW]
wbm_dat_i  in  NUM_MASTERS*DW  master write data
wbm_sel_i  in  NUM_MASTERS*DW/8  master byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_cyc_i  in  NUM_MASTERS  cycle requests
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cti_i  in  NUM_MASTERS*3  cycle type
wbm_bte_i  in  NUM_MASTERS*2  burst type
wbm_dat_o  out  DW  read data, broadcast to all masters
wbm_ack_o  out  NUM_MASTERS  per-master ack
wbm_err_o  out  NUM_MASTERS  per-master err
wbm_rty_o  out  NUM_MASTERS  per-master rty
wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  to upsizer
wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW, 1, 1, 1  from upsizer
grant_o  out  NUM_MASTERS  one-hot current grant, for debug and performance counters

Behaviour:
- Reset (async): state=IDLE, grant=0, last-grant pointer=NUM_MASTERS-1, watchdog=0.
  - All wbs_cyc_o/wbs_stb_o and wbm_ack_o/err_o/rty_o = 0; remaining wbs_* outputs = 0.
- States:
  - IDLE, BUSY, TOUT.
- IDLE:
  - If any wbm_cyc_i is set, register a one-hot grant to the first requester after the last-grant pointer (cyclic search); go to BUSY.
  - Arbitration latency is 1 cycle: wbs_cyc_o rises the cycle after the request is seen.
- BUSY:
  - wbs_* outputs are combinationally muxed from the granted master; wbs_cyc_o = granted wbm_cyc_i.
  - wbs_ack_i/err_i/rty_i route only to the granted master's bit; others read 0.
  - wbm_dat_o = wbs_dat_i, unconditionally.
- Release:
  - When the granted wbm_cyc_i is 0, go to IDLE, update the last-grant pointer, clear grant. The idle cycle is combinational-free, so there is exactly one dead cycle between owners.
  - Grant never changes while the owner holds cyc, including cti=001/010 bursts and multi-beat upsizer write batches.
- Watchdog:
  - Counts in BUSY while wbs_stb_o=1 and none of ack/err/rty is set.
  - Clears on any termination or when stb drops.
  - At count==TIMEOUT, go to TOUT.
- TOUT (one cycle):
  - wbs_cyc_o=wbs_stb_o=0, aborting the upsizer transaction.
  - wbm_err_o[grant]=1 for exactly this cycle.
  - Watchdog cleared; next state BUSY if the owner still holds cyc, else IDLE.
- Simultaneous events:
  - Owner drops cyc in the same cycle as another master requests: release first; the new grant is issued from IDLE in the following cycle.
  - ack and a watchdog expiry in the same cycle: ack wins, counter clears.
- Reset asserted mid-transfer: all outputs drop immediately (async); the pointer returns to its reset value.
- A master is never granted unless its wbm_cyc_i is set in the arbitration cycle.

Test Plan:
- Single master 0 classic write, adr=0x100, dat=0xDEADBEEF, upsizer acks in 2 cycles -> wbs_cyc_o rises 1 cycle after wbm_cyc_i[0]; wbm_ack_o=0001 for one cycle; all other acks 0.
- Masters 0..3 request continuously, one beat each -> grant_o sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between owners.
- Master 1 runs a 4-beat incrementing burst (cti=010, last beat cti=111) while master 2 requests -> grant stays 0010 for all 4 acks; master 2 is granted only after master 1 drops cyc.
- TIMEOUT=8, master 3 strobes and the upsizer never acks -> after 8 stalled cycles wbs_cyc_o=0 for one cycle and wbm_err_o=1000 for one cycle.
- Assert wb_rst_i asynchronously mid-burst of master 0 -> wbs_cyc_o and grant_o go to 0 the same instant; after release, a request from master 0 is granted first (pointer=NUM_MASTERS-1).
- Owner drops cyc in the same cycle master 2 asserts cyc -> grant_o goes 0 for one cycle, then 0100; no overlapping wbs_cyc_o ownership.
